// File: rtl/mouse_master_sm_if.sv
// Byte-level handshake between the mouse master sequencer and the PS/2
// transmitter/receiver datapath.
interface mouse_master_sm_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic       BYTE_READY;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;

  modport master (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    input  BYTE_SENT, BYTE_READY, BYTE_READ, BYTE_ERROR_CODE
  );

  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    output BYTE_SENT, BYTE_READY, BYTE_READ, BYTE_ERROR_CODE
  );
endinterface

// File: rtl/mouse_master_sm.sv
// PS/2 mouse master sequencer: power-up command/ack protocol with IntelliMouse
// wheel knock, then stream packet parsing with a one-cycle interrupt per packet.
module mouse_master_sm #(
  parameter int unsigned INIT_WAIT = 500000,
  parameter int unsigned TIMEOUT   = 5000000
) (
  input  logic              CLK,
  input  logic              RESET,
  mouse_master_sm_if.master bus,
  output logic [7:0]        MOUSE_STATUS,
  output logic [7:0]        MOUSE_DX,
  output logic [7:0]        MOUSE_DY,
  output logic [7:0]        MOUSE_DZ,
  output logic              WHEEL_EN,
  output logic              SEND_INTERRUPT,
  output logic [4:0]        MASTER_STATE
);

  typedef enum logic [4:0] {
    S_INIT          = 5'd0,
    S_TX            = 5'd1,
    S_WAIT_SENT     = 5'd2,
    S_WAIT_ACK      = 5'd3,
    S_WAIT_SELFTEST = 5'd4,
    S_WAIT_ID       = 5'd5,
    S_WAIT_ID2      = 5'd6,
    S_STREAM        = 5'd7
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cmd_idx, cmd_idx_nxt;
  logic [31:0] timer;
  logic [1:0]  pkt_idx;
  logic [7:0]  sh_status, sh_dx, sh_dy;
  logic        rx_ok;
  logic        read_en;
  logic        publish;

  // The whole command sequence shares one TX/WAIT_SENT/WAIT_ACK step, indexed by cmd_idx.
  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    cmd_byte = 8'hFF;
      4'd1:    cmd_byte = 8'hF3;
      4'd2:    cmd_byte = 8'hC8;
      4'd3:    cmd_byte = 8'hF3;
      4'd4:    cmd_byte = 8'h64;
      4'd5:    cmd_byte = 8'hF3;
      4'd6:    cmd_byte = 8'h50;
      4'd7:    cmd_byte = 8'hF2;
      4'd8:    cmd_byte = 8'hF4;
      default: cmd_byte = 8'h00;
    endcase
  endfunction

  assign rx_ok = bus.BYTE_READY && (bus.BYTE_ERROR_CODE == 2'b00);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_INIT;
      cmd_idx <= '0;
    end else begin
      state   <= state_nxt;
      cmd_idx <= cmd_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_idx_nxt = cmd_idx;
    case (state)
      S_INIT: begin
        if (timer == INIT_WAIT - 1) begin
          state_nxt   = S_TX;
          cmd_idx_nxt = '0;
        end
      end
      S_TX:        state_nxt = S_WAIT_SENT;
      S_WAIT_SENT: if (bus.BYTE_SENT) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (bus.BYTE_READY) begin
          if (rx_ok && bus.BYTE_READ == 8'hFA) begin
            case (cmd_idx)
              4'd0:    state_nxt = S_WAIT_SELFTEST;
              4'd7:    state_nxt = S_WAIT_ID2;
              4'd8:    state_nxt = S_STREAM;
              default: begin
                state_nxt   = S_TX;
                cmd_idx_nxt = cmd_idx + 4'd1;
              end
            endcase
          end else begin
            state_nxt = S_INIT;
          end
        end
      end
      S_WAIT_SELFTEST: begin
        if (bus.BYTE_READY)
          state_nxt = (rx_ok && bus.BYTE_READ == 8'hAA) ? S_WAIT_ID : S_INIT;
      end
      S_WAIT_ID: begin
        if (bus.BYTE_READY) begin
          if (rx_ok && bus.BYTE_READ == 8'h00) begin
            state_nxt   = S_TX;
            cmd_idx_nxt = 4'd1;
          end else begin
            state_nxt = S_INIT;
          end
        end
      end
      S_WAIT_ID2: begin
        if (bus.BYTE_READY) begin
          if (rx_ok && (bus.BYTE_READ == 8'h03 || bus.BYTE_READ == 8'h00)) begin
            state_nxt   = S_TX;
            cmd_idx_nxt = 4'd8;
          end else begin
            state_nxt = S_INIT;
          end
        end
      end
      S_STREAM: state_nxt = S_STREAM;
      default:  state_nxt = S_INIT;
    endcase
    if (state != S_INIT && state != S_STREAM && timer == TIMEOUT - 1)
      state_nxt = S_INIT;
  end

  always_comb begin
    bus.SEND_BYTE    = (state == S_TX);
    bus.BYTE_TO_SEND = 8'h00;
    if (state == S_TX || state == S_WAIT_SENT || state == S_WAIT_ACK)
      bus.BYTE_TO_SEND = cmd_byte(cmd_idx);
    read_en = (state == S_WAIT_ACK) || (state == S_WAIT_SELFTEST) ||
              (state == S_WAIT_ID)  || (state == S_WAIT_ID2) || (state == S_STREAM);
    bus.READ_ENABLE = read_en;
    MASTER_STATE    = state;
    publish = (state == S_STREAM) && rx_ok &&
              ((pkt_idx == 2'd2 && !WHEEL_EN) || pkt_idx == 2'd3);
  end

  // Saturates rather than wrapping so an idle STREAM cannot alias back to zero.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      timer <= '0;
    else if (state_nxt != state || (bus.BYTE_READY && read_en))
      timer <= '0;
    else if (timer != '1)
      timer <= timer + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      WHEEL_EN <= 1'b0;
    else if (state == S_WAIT_ID2 && rx_ok) begin
      if (bus.BYTE_READ == 8'h03)      WHEEL_EN <= 1'b1;
      else if (bus.BYTE_READ == 8'h00) WHEEL_EN <= 1'b0;
    end
  end

  // Packet bytes land in shadows; outputs change only when a packet completes cleanly.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pkt_idx        <= '0;
      sh_status      <= '0;
      sh_dx          <= '0;
      sh_dy          <= '0;
      MOUSE_STATUS   <= '0;
      MOUSE_DX       <= '0;
      MOUSE_DY       <= '0;
      MOUSE_DZ       <= '0;
      SEND_INTERRUPT <= 1'b0;
    end else begin
      SEND_INTERRUPT <= publish;
      if (state != S_STREAM) begin
        pkt_idx <= '0;
        if (state == S_WAIT_ID2 && rx_ok && bus.BYTE_READ == 8'h00)
          MOUSE_DZ <= '0;
      end else if (bus.BYTE_READY) begin
        if (bus.BYTE_ERROR_CODE != 2'b00) begin
          pkt_idx <= '0;
        end else begin
          case (pkt_idx)
            2'd0: begin
              if (bus.BYTE_READ[3]) begin
                sh_status <= bus.BYTE_READ;
                pkt_idx   <= 2'd1;
              end
            end
            2'd1: begin
              sh_dx   <= bus.BYTE_READ;
              pkt_idx <= 2'd2;
            end
            2'd2: begin
              if (WHEEL_EN) begin
                sh_dy   <= bus.BYTE_READ;
                pkt_idx <= 2'd3;
              end else begin
                MOUSE_STATUS <= sh_status;
                MOUSE_DX     <= sh_dx;
                MOUSE_DY     <= bus.BYTE_READ;
                MOUSE_DZ     <= '0;
                pkt_idx      <= 2'd0;
              end
            end
            default: begin
              MOUSE_STATUS <= sh_status;
              MOUSE_DX     <= sh_dx;
              MOUSE_DY     <= sh_dy;
              MOUSE_DZ     <= {{4{bus.BYTE_READ[3]}}, bus.BYTE_READ[3:0]};
              pkt_idx      <= 2'd0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed bench for mouse_master_sm: acting as the transceiver datapath and the
// mouse, with hand-computed expectations checked by immediate assertions.
module tb_mouse_master_sm;

  localparam int unsigned INIT_WAIT = 10;
  localparam int unsigned TIMEOUT   = 1000;
  localparam logic [4:0]  ST_INIT   = 5'd0;
  localparam logic [4:0]  ST_STREAM = 5'd7;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ;
  logic       WHEEL_EN, SEND_INTERRUPT;
  logic [4:0] MASTER_STATE;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned send_cnt = 0;
  int unsigned irq_cnt = 0;
  int unsigned overlap_cnt = 0;

  mouse_master_sm_if bus_if ();

  mouse_master_sm #(.INIT_WAIT(INIT_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .bus            (bus_if.master),
    .MOUSE_STATUS   (MOUSE_STATUS),
    .MOUSE_DX       (MOUSE_DX),
    .MOUSE_DY       (MOUSE_DY),
    .MOUSE_DZ       (MOUSE_DZ),
    .WHEEL_EN       (WHEEL_EN),
    .SEND_INTERRUPT (SEND_INTERRUPT),
    .MASTER_STATE   (MASTER_STATE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (bus_if.SEND_BYTE) send_cnt++;
    if (SEND_INTERRUPT) irq_cnt++;
    if (bus_if.SEND_BYTE && bus_if.READ_ENABLE) overlap_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_send(input int unsigned limit, output bit found);
    int unsigned n;
    found = 1'b0;
    n = 0;
    while (!found && n < limit) begin
      if (bus_if.SEND_BYTE === 1'b1) found = 1'b1;
      else begin
        @(negedge CLK);
        n++;
      end
    end
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] code);
    bus_if.BYTE_READ       = b;
    bus_if.BYTE_ERROR_CODE = code;
    bus_if.BYTE_READY      = 1'b1;
    @(negedge CLK);
    bus_if.BYTE_READY      = 1'b0;
    bus_if.BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic do_cmd(input logic [7:0] exp, input logic [7:0] ack);
    bit f;
    wait_send(3000, f);
    chk("cmd_seen", 32'(f), 32'd1);
    chk("cmd_byte", 32'(bus_if.BYTE_TO_SEND), 32'(exp));
    @(negedge CLK);
    chk("send_one_cycle", 32'(bus_if.SEND_BYTE), 32'd0);
    chk("cmd_held", 32'(bus_if.BYTE_TO_SEND), 32'(exp));
    bus_if.BYTE_SENT = 1'b1;
    @(negedge CLK);
    bus_if.BYTE_SENT = 1'b0;
    rx(ack, 2'b00);
  endtask

  task automatic power_up(input logic [7:0] id);
    do_cmd(8'hFF, 8'hFA);
    rx(8'hAA, 2'b00);
    rx(8'h00, 2'b00);
    do_cmd(8'hF3, 8'hFA);
    do_cmd(8'hC8, 8'hFA);
    do_cmd(8'hF3, 8'hFA);
    do_cmd(8'h64, 8'hFA);
    do_cmd(8'hF3, 8'hFA);
    do_cmd(8'h50, 8'hFA);
    do_cmd(8'hF2, 8'hFA);
    rx(id, 2'b00);
    do_cmd(8'hF4, 8'hFA);
    chk("stream_reached", 32'(MASTER_STATE), 32'(ST_STREAM));
  endtask

  task automatic check_pub(input string tag, input logic [7:0] s, input logic [7:0] x,
                           input logic [7:0] y, input logic [7:0] z);
    chk({tag, "_irq"}, 32'(SEND_INTERRUPT), 32'd1);
    chk({tag, "_status"}, 32'(MOUSE_STATUS), 32'(s));
    chk({tag, "_dx"}, 32'(MOUSE_DX), 32'(x));
    chk({tag, "_dy"}, 32'(MOUSE_DY), 32'(y));
    chk({tag, "_dz"}, 32'(MOUSE_DZ), 32'(z));
    @(negedge CLK);
    chk({tag, "_irq_single"}, 32'(SEND_INTERRUPT), 32'd0);
  endtask

  initial begin
    bit          f;
    int unsigned base;
    int unsigned n;

    RESET                  = 1'b0;
    bus_if.BYTE_SENT       = 1'b0;
    bus_if.BYTE_READY      = 1'b0;
    bus_if.BYTE_READ       = 8'h00;
    bus_if.BYTE_ERROR_CODE = 2'b00;
    repeat (3) @(negedge CLK);

    chk("rst_state", 32'(MASTER_STATE), 32'(ST_INIT));
    chk("rst_send", 32'(bus_if.SEND_BYTE), 32'd0);
    chk("rst_rden", 32'(bus_if.READ_ENABLE), 32'd0);
    chk("rst_tx_byte", 32'(bus_if.BYTE_TO_SEND), 32'd0);
    chk("rst_outputs", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ}, 32'd0);
    chk("rst_flags", {30'd0, WHEEL_EN, SEND_INTERRUPT}, 32'd0);

    // Wheel mouse power-up
    base  = send_cnt;
    RESET = 1'b1;
    power_up(8'h03);
    chk("cmd_count", send_cnt - base, 32'd9);
    chk("wheel_en", 32'(WHEEL_EN), 32'd1);

    rx(8'h09, 2'b00);
    rx(8'h1E, 2'b00);
    rx(8'h2D, 2'b00);
    chk("wheel_no_irq_at_3", 32'(SEND_INTERRUPT), 32'd0);
    rx(8'h0F, 2'b00);
    check_pub("pkt4a", 8'h09, 8'h1E, 8'h2D, 8'hFF);

    rx(8'h18, 2'b00);
    rx(8'h01, 2'b00);
    rx(8'h02, 2'b00);
    rx(8'h53, 2'b00);
    check_pub("pkt4b", 8'h18, 8'h01, 8'h02, 8'h03);

    // Asynchronous reset in the middle of a packet
    rx(8'h09, 2'b00);
    rx(8'h05, 2'b00);
    #2 RESET = 1'b0;
    #1;
    chk("async_rst_outputs", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ}, 32'd0);
    chk("async_rst_state", 32'(MASTER_STATE), 32'(ST_INIT));
    chk("async_rst_wheel", 32'(WHEEL_EN), 32'd0);
    @(negedge CLK);
    chk("async_rst_no_irq", 32'(SEND_INTERRUPT), 32'd0);
    @(negedge CLK);

    // Non-wheel mouse
    RESET = 1'b1;
    power_up(8'h00);
    chk("nowheel_en", 32'(WHEEL_EN), 32'd0);
    rx(8'h08, 2'b00);
    rx(8'h9F, 2'b00);
    rx(8'h77, 2'b00);
    check_pub("pkt3a", 8'h08, 8'h9F, 8'h77, 8'h00);

    // Resync: byte without bit3 at index 0 is dropped
    rx(8'h00, 2'b00);
    chk("resync_no_irq", 32'(SEND_INTERRUPT), 32'd0);
    rx(8'h08, 2'b00);
    rx(8'h11, 2'b00);
    chk("resync_no_early_irq", 32'(SEND_INTERRUPT), 32'd0);
    rx(8'h22, 2'b00);
    check_pub("pkt3b", 8'h08, 8'h11, 8'h22, 8'h00);

    // Parity error on byte 2 discards the packet
    rx(8'h09, 2'b00);
    rx(8'h33, 2'b00);
    rx(8'h44, 2'b01);
    chk("perr_no_irq", 32'(SEND_INTERRUPT), 32'd0);
    @(negedge CLK);
    chk("perr_no_irq2", 32'(SEND_INTERRUPT), 32'd0);
    chk("perr_outputs_kept", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ}, 32'h0811_2200);
    chk("perr_stays_stream", 32'(MASTER_STATE), 32'(ST_STREAM));
    rx(8'h0A, 2'b00);
    rx(8'h44, 2'b00);
    rx(8'h55, 2'b00);
    check_pub("pkt3c", 8'h0A, 8'h44, 8'h55, 8'h00);

    // Bad ack to F3 restarts from INIT
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    do_cmd(8'hFF, 8'hFA);
    rx(8'hAA, 2'b00);
    rx(8'h00, 2'b00);
    do_cmd(8'hF3, 8'hFE);
    chk("nack_to_init", 32'(MASTER_STATE), 32'(ST_INIT));
    wait_send(3000, f);
    chk("nack_restart_seen", 32'(f), 32'd1);
    chk("nack_restart_ff", 32'(bus_if.BYTE_TO_SEND), 32'hFF);

    // Withheld BYTE_SENT times out back to INIT
    n = 0;
    while (MASTER_STATE !== ST_INIT && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk("timeout_to_init", 32'(MASTER_STATE), 32'(ST_INIT));
    chk("timeout_duration", 32'(n >= 995 && n <= 1005), 32'd1);
    wait_send(3000, f);
    chk("timeout_restart_seen", 32'(f), 32'd1);
    chk("timeout_restart_ff", 32'(bus_if.BYTE_TO_SEND), 32'hFF);

    chk("irq_total", irq_cnt, 32'd5);
    chk("no_send_read_overlap", overlap_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
